// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared store-buffer types: request source, queued entry, drain state
package store_pkg;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_src_e;

  typedef struct packed {
    logic [29:0] wordAddr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_e;

endpackage

// File: rtl/store_lane_fmt.sv
// rtl/store_lane_fmt.sv - lane replication, byte enables and misalignment detect for one store
module store_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  storeSrc,
  input  logic [31:0] storeAddress,
  input  logic [31:0] writeData,
  output logic [31:0] fmtData,
  output logic [3:0]  fmtBe,
  output logic        misaligned
);

  // Encoding 2'b11 falls through to the word case.
  always_comb begin
    fmtData    = writeData;
    fmtBe      = 4'b1111;
    misaligned = (storeAddress[1:0] != 2'b00);
    case (store_src_e'(storeSrc))
      ST_SB: begin
        fmtData    = {4{writeData[7:0]}};
        fmtBe      = 4'b0001 << storeAddress[1:0];
        misaligned = 1'b0;
      end
      ST_SH: begin
        fmtData    = {2{writeData[15:0]}};
        fmtBe      = storeAddress[1] ? 4'b1100 : 4'b0011;
        misaligned = storeAddress[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - posted-store FIFO drained to memory over req/ack
// Optional STORE_FWD_EN adds loadAddress/loadHit for load-hazard detection.
module store_buffer_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        storeValid,
  output logic        storeReady,
  input  logic [1:0]  storeSrc,
  input  logic [31:0] storeAddress,
  input  logic [31:0] writeData,
  output logic        misalignedErr,
  output logic        memReq,
  input  logic        memAck,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memByteEn,
  output logic        empty,
  output logic        full
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0] loadAddress,
  output logic        loadHit
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  st_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_next;
  drain_state_e       state, state_next;
  logic [31:0]        fmt_data;
  logic [3:0]         fmt_be;
  logic               misaligned;
  logic               handshake, push, pop;
  st_entry_t          head;

  store_lane_fmt u_fmt (
    .storeSrc     (storeSrc),
    .storeAddress (storeAddress),
    .writeData    (writeData),
    .fmtData      (fmt_data),
    .fmtBe        (fmt_be),
    .misaligned   (misaligned)
  );

  assign full       = (count == CNT_W'(DEPTH));
  assign storeReady = !full;
  assign handshake  = storeValid && storeReady;
  assign push       = handshake && !misaligned;
  assign pop        = (state == ISSUE) && memAck;
  assign empty      = (count == '0) && (state == IDLE);
  assign head       = entries[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  // Stay in ISSUE whenever anything remains after this cycle so a steady
  // push+pop stream keeps memReq high with no bubble.
  always_comb begin
    state_next = state;
    memReq     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0)
          state_next = ISSUE;
      end
      ISSUE: begin
        memReq = 1'b1;
        if (memAck && (count_next == '0))
          state_next = IDLE;
      end
    endcase
  end

  assign memAddr   = memReq ? {head.wordAddr, 2'b00} : 32'h0;
  assign memWData  = memReq ? head.data : 32'h0;
  assign memByteEn = memReq ? head.be : 4'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      misalignedErr <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      misalignedErr <= handshake && misaligned;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push)
      entries[wr_ptr] <= '{wordAddr: storeAddress[31:2], data: fmt_data, be: fmt_be};
  end

`ifdef STORE_FWD_EN
  always_comb begin
    loadHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          ({entries[rd_ptr + PTR_W'(i)].wordAddr, 2'b00} == (loadAddress & ~32'h3)))
        loadHit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb/tb_store_buffer_ctrl.sv - directed self-checking bench for store_buffer_ctrl
module tb_store_buffer_ctrl;

  logic        clk;
  logic        reset;
  logic        storeValid;
  logic        storeReady;
  logic [1:0]  storeSrc;
  logic [31:0] storeAddress;
  logic [31:0] writeData;
  logic        misalignedErr;
  logic        memReq;
  logic        memAck;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        empty;
  logic        full;
`ifdef STORE_FWD_EN
  logic [31:0] loadAddress;
  logic        loadHit;
`endif

  int checks;
  int failures;

  store_buffer_ctrl #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .storeValid    (storeValid),
    .storeReady    (storeReady),
    .storeSrc      (storeSrc),
    .storeAddress  (storeAddress),
    .writeData     (writeData),
    .misalignedErr (misalignedErr),
    .memReq        (memReq),
    .memAck        (memAck),
    .memAddr       (memAddr),
    .memWData      (memWData),
    .memByteEn     (memByteEn),
    .empty         (empty),
    .full          (full)
`ifdef STORE_FWD_EN
    ,
    .loadAddress   (loadAddress),
    .loadHit       (loadHit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one store for exactly one rising edge; returns on the following falling edge.
  task automatic push_store(input logic [1:0] src, input logic [31:0] addr, input logic [31:0] wd);
    storeValid   = 1'b1;
    storeSrc     = src;
    storeAddress = addr;
    writeData    = wd;
    @(negedge clk);
    storeValid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL reset_memReq got=%0b exp=0", memReq); end
    checks++; if (misalignedErr !== 1'b0) begin failures++; $display("FAIL reset_misalignedErr got=%0b exp=0", misalignedErr); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (storeReady !== 1'b1) begin failures++; $display("FAIL reset_storeReady got=%0b exp=1", storeReady); end
    checks++; if ({memAddr, memWData, memByteEn} !== 68'h0) begin
      failures++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", memAddr, memWData, memByteEn);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || memReq !== 1'b0) begin
      failures++; $display("FAIL reset_release got empty=%0b memReq=%0b exp 1/0", empty, memReq);
    end
  endtask

  task automatic test_sb;
    memAck = 1'b0;
    push_store(2'b00, 32'h0000_0103, 32'h0000_00AB);
    checks++; if (memReq !== 1'b0 || empty !== 1'b0) begin
      failures++; $display("FAIL sb_latency got memReq=%0b empty=%0b exp 0/0", memReq, empty);
    end
    @(negedge clk);
    checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL sb_memReq got=%0b exp=1", memReq); end
    checks++; if (memAddr !== 32'h0000_0100) begin failures++; $display("FAIL sb_memAddr got=%h exp=00000100", memAddr); end
    checks++; if (memWData !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_memWData got=%h exp=abababab", memWData); end
    checks++; if (memByteEn !== 4'b1000) begin failures++; $display("FAIL sb_memByteEn got=%b exp=1000", memByteEn); end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checks++; if (memReq !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL sb_drained got memReq=%0b empty=%0b exp 0/1", memReq, empty);
    end
  endtask

  task automatic test_sh_misaligned;
    memAck = 1'b1;
    push_store(2'b01, 32'h0000_0202, 32'h0000_1234);
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL sh_idle_ack got memReq=%0b exp=0", memReq); end
    @(negedge clk);
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0000_0200) begin
      failures++; $display("FAIL sh_issue got memReq=%0b addr=%h exp 1/00000200", memReq, memAddr);
    end
    checks++; if (memWData !== 32'h1234_1234) begin failures++; $display("FAIL sh_memWData got=%h exp=12341234", memWData); end
    checks++; if (memByteEn !== 4'b1100) begin failures++; $display("FAIL sh_memByteEn got=%b exp=1100", memByteEn); end
    @(negedge clk);
    memAck = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sh_drained got empty=%0b exp=1", empty); end

    storeValid   = 1'b1;
    storeSrc     = 2'b01;
    storeAddress = 32'h0000_0201;
    writeData    = 32'h0000_5678;
    #1;
    checks++; if (storeReady !== 1'b1) begin failures++; $display("FAIL mis_storeReady got=%0b exp=1", storeReady); end
    @(negedge clk);
    storeValid = 1'b0;
    checks++; if (misalignedErr !== 1'b1) begin failures++; $display("FAIL mis_sh_pulse got=%0b exp=1", misalignedErr); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mis_sh_not_queued got empty=%0b exp=1", empty); end
    @(negedge clk);
    checks++; if (misalignedErr !== 1'b0 || memReq !== 1'b0) begin
      failures++; $display("FAIL mis_sh_after got err=%0b memReq=%0b exp 0/0", misalignedErr, memReq);
    end
    push_store(2'b10, 32'h0000_0402, 32'hDEAD_BEEF);
    checks++; if (misalignedErr !== 1'b1 || empty !== 1'b1) begin
      failures++; $display("FAIL mis_sw got err=%0b empty=%0b exp 1/1", misalignedErr, empty);
    end
    @(negedge clk);
    checks++; if (memReq !== 1'b0 || misalignedErr !== 1'b0) begin
      failures++; $display("FAIL mis_sw_after got memReq=%0b err=%0b exp 0/0", memReq, misalignedErr);
    end
  endtask

  task automatic test_full;
    memAck = 1'b0;
    for (int k = 0; k < 4; k++)
      push_store(2'b10, 32'h0000_0400 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    checks++; if (full !== 1'b1 || storeReady !== 1'b0) begin
      failures++; $display("FAIL full_flags got full=%0b ready=%0b exp 1/0", full, storeReady);
    end
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0000_0400) begin
      failures++; $display("FAIL full_head got memReq=%0b addr=%h exp 1/00000400", memReq, memAddr);
    end
    storeValid   = 1'b1;
    storeSrc     = 2'b11;
    storeAddress = 32'h0000_0410;
    writeData    = 32'hA000_0004;
    @(negedge clk);
    checks++; if (storeReady !== 1'b0 || memAddr !== 32'h0000_0400) begin
      failures++; $display("FAIL full_hold got ready=%0b addr=%h exp 0/00000400", storeReady, memAddr);
    end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checks++; if (storeReady !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL full_after_pop got ready=%0b full=%0b exp 1/0", storeReady, full);
    end
    @(negedge clk);
    storeValid = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_refill got=%0b exp=1", full); end
    memAck = 1'b1;
    for (int k = 1; k < 5; k++) begin
      for (int w = 0; w < 10 && memReq !== 1'b1; w++) @(negedge clk);
      checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL full_drain_timeout k=%0d got memReq=%0b exp=1", k, memReq); end
      checks++; if (memAddr !== 32'h0000_0400 + 32'(4 * k) || memWData !== 32'hA000_0000 + 32'(k)) begin
        failures++; $display("FAIL full_order k=%0d got addr=%h data=%h exp %h/%h", k, memAddr, memWData,
                             32'h0000_0400 + 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
      @(negedge clk);
    end
    memAck = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got empty=%0b exp=1", empty); end
  endtask

  task automatic test_back_to_back;
    memAck = 1'b1;
    for (int j = 0; j < 10; j++) begin
      push_store(2'b10, 32'h0000_0500 + 32'(4 * j), 32'hB000_0000 + 32'(j));
      if (j >= 1) begin
        checks++; if (memReq !== 1'b1 || storeReady !== 1'b1) begin
          failures++; $display("FAIL b2b_stream j=%0d got memReq=%0b ready=%0b exp 1/1", j, memReq, storeReady);
        end
        checks++; if (memAddr !== 32'h0000_0500 + 32'(4 * (j - 1))) begin
          failures++; $display("FAIL b2b_order j=%0d got addr=%h exp %h", j, memAddr, 32'h0000_0500 + 32'(4 * (j - 1)));
        end
      end
    end
    for (int k = 8; k < 10; k++) begin
      checks++; if (memReq !== 1'b1 || memAddr !== 32'h0000_0500 + 32'(4 * k)) begin
        failures++; $display("FAIL b2b_tail k=%0d got memReq=%0b addr=%h exp 1/%h", k, memReq, memAddr, 32'h0000_0500 + 32'(4 * k));
      end
      @(negedge clk);
    end
    memAck = 1'b0;
    checks++; if (empty !== 1'b1 || memReq !== 1'b0) begin
      failures++; $display("FAIL b2b_drained got empty=%0b memReq=%0b exp 1/0", empty, memReq);
    end
  endtask

  task automatic test_reset_mid_drain;
    memAck = 1'b0;
    for (int k = 0; k < 3; k++)
      push_store(2'b10, 32'h0000_0600 + 32'(4 * k), 32'hC000_0000 + 32'(k));
    checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL rst_pre got memReq=%0b exp=1", memReq); end
    #2 reset = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL rst_async got memReq=%0b empty=%0b exp 0/1", memReq, empty);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL rst_release got empty=%0b full=%0b exp 1/0", empty, full);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL rst_stale k=%0d got memReq=%0b exp=0", k, memReq); end
    end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_fwd;
    memAck      = 1'b0;
    loadAddress = 32'h0000_0302;
    #1;
    checks++; if (loadHit !== 1'b0) begin failures++; $display("FAIL fwd_empty got=%0b exp=0", loadHit); end
    push_store(2'b10, 32'h0000_0300, 32'h5555_5555);
    checks++; if (loadHit !== 1'b1) begin failures++; $display("FAIL fwd_queued got=%0b exp=1", loadHit); end
    loadAddress = 32'h0000_0304;
    #1;
    checks++; if (loadHit !== 1'b0) begin failures++; $display("FAIL fwd_other_word got=%0b exp=0", loadHit); end
    loadAddress = 32'h0000_0302;
    @(negedge clk);
    checks++; if (loadHit !== 1'b1 || memReq !== 1'b1) begin
      failures++; $display("FAIL fwd_issue got hit=%0b memReq=%0b exp 1/1", loadHit, memReq);
    end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checks++; if (loadHit !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL fwd_after_ack got hit=%0b empty=%0b exp 0/1", loadHit, empty);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    storeValid   = 1'b0;
    storeSrc     = 2'b00;
    storeAddress = 32'h0;
    writeData    = 32'h0;
    memAck       = 1'b0;
`ifdef STORE_FWD_EN
    loadAddress  = 32'h0;
`endif
    test_reset;
    test_sb;
    test_sh_misaligned;
    test_full;
    test_back_to_back;
    test_reset_mid_drain;
`ifdef STORE_FWD_EN
    test_fwd;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
